// File: rtl/alu_pkg.sv
// Shared types for the ALU command front-end: opcodes, the queued command record
// and the issue FSM state encoding.
package alu_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_MUL = 2'b10;
    localparam logic [1:0] ALU_NOP = 2'b11;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [1:0] sel;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        HOLD
    } issue_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous DEPTH-entry command FIFO with occupancy count; head entry is
// presented combinationally on pop_data.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  alu_cmd_t                 push_data,
    input  logic                     pop,
    output alu_cmd_t                 pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    alu_cmd_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: storage has no reset; pointers and level alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_issue.sv
// Command front-end for the combinational 8-bit ALU: queues commands, issues one
// at a time onto registered alu_* outputs and returns the captured result.
module alu_op_issue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [7:0]               cmd_a,
    input  logic [7:0]               cmd_b,
    input  logic                     cmd_cin,
    input  logic [1:0]               cmd_sel,
    output logic [7:0]               alu_a,
    output logic [7:0]               alu_b,
    output logic                     alu_cin,
    output logic [1:0]               alu_sel,
    input  logic [15:0]              alu_result,
    input  logic                     alu_carry,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [15:0]              rsp_result,
    output logic                     rsp_carry,
    output logic [1:0]               rsp_sel,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy
);

    issue_state_t state_q;
    issue_state_t state_d;
    alu_cmd_t     push_cmd;
    alu_cmd_t     head_cmd;
    logic         fifo_full;
    logic         fifo_empty;
    logic         push;
    logic         pop;
    logic         capture;
    logic         release_rsp;

    assign push_cmd  = '{a: cmd_a, b: cmd_b, cin: cmd_cin, sel: cmd_sel};
    assign cmd_ready = rst_n && !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (state_q != IDLE) || (level != '0);

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_cmd),
        .pop       (pop),
        .pop_data  (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    // NOTE: sequential blocks use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: combinational blocks assign defaults first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = EXEC;
            EXEC:    state_d = HOLD;
            HOLD:    if (rsp_ready) state_d = fifo_empty ? IDLE : EXEC;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop         = 1'b0;
        capture     = 1'b0;
        release_rsp = 1'b0;
        case (state_q)
            IDLE: pop = !fifo_empty;
            EXEC: capture = 1'b1;
            HOLD: begin
                release_rsp = rsp_ready;
                pop         = rsp_ready && !fifo_empty;
            end
            default: ;
        endcase
    end

    // ALU operand registers; alu_sel parks on NOP whenever nothing is executing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_cin <= 1'b0;
            alu_sel <= ALU_NOP;
        end else if (pop) begin
            alu_a   <= head_cmd.a;
            alu_b   <= head_cmd.b;
            alu_cin <= head_cmd.cin;
            alu_sel <= head_cmd.sel;
        end else if (capture) begin
            alu_sel <= ALU_NOP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_sel    <= ALU_NOP;
        end else if (capture) begin
            rsp_valid  <= 1'b1;
            rsp_result <= alu_result;
            rsp_carry  <= alu_carry;
            rsp_sel    <= alu_sel;
        end else if (release_rsp) begin
            rsp_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed bench for alu_op_issue using the XOR-concatenation ALU stub.
module tb_alu_op_issue;
    import alu_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic        cmd_cin;
    logic [1:0]  cmd_sel;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_cin;
    logic [1:0]  alu_sel;
    logic [15:0] alu_result;
    logic        alu_carry;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_carry;
    logic [1:0]  rsp_sel;
    logic [2:0]  level;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        cin;
        logic [1:0]  sel;
        logic [15:0] exp_result;
        logic        exp_carry;
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] q_a   [12];
    logic [7:0] q_b   [12];
    logic       q_cin [12];
    logic [1:0] q_sel [12];

    alu_op_issue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_cin    (cmd_cin),
        .cmd_sel    (cmd_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cin    (alu_cin),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_sel    (rsp_sel),
        .level      (level),
        .busy       (busy)
    );

    assign alu_result = {alu_a, alu_b} ^ {14'b0, alu_sel};
    assign alu_carry  = alu_cin;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] stub(input logic [7:0] a, input logic [7:0] b, input logic [1:0] sel);
        return {a, b} ^ {14'b0, sel};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic [1:0] sel);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_cin   = cin;
        cmd_sel   = sel;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && (busy || rsp_valid); i++) @(negedge clk);
        check("idle_wait_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int k;
        int tx;
        int rx;
        int last;
        int hs;
        int vcount;
        logic acc;

        vecs[0] = '{8'h12, 8'h34, 1'b1, ALU_ADD, 16'h1234, 1'b1};
        vecs[1] = '{8'h00, 8'h00, 1'b0, ALU_NOP, 16'h0003, 1'b0};
        vecs[2] = '{8'hFF, 8'h01, 1'b0, ALU_SUB, 16'hFF00, 1'b0};
        vecs[3] = '{8'h80, 8'h80, 1'b1, ALU_MUL, 16'h8082, 1'b1};
        vecs[4] = '{8'hA5, 8'h5A, 1'b0, ALU_ADD, 16'hA55A, 1'b0};
        for (int i = 0; i < 12; i++) begin
            q_a[i]   = 8'(8'h10 + i);
            q_b[i]   = 8'hA0 ^ 8'(i);
            q_cin[i] = 1'(i % 2);
            q_sel[i] = 2'(i % 4);
        end

        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_cin   = 1'b0;
        cmd_sel   = '0;
        rsp_ready = 1'b1;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_cin", 32'(alu_cin), 32'd0);
        check("rst_alu_sel", 32'(alu_sel), 32'd3);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_result", 32'(rsp_result), 32'd0);
        check("rst_rsp_carry", 32'(rsp_carry), 32'd0);
        check("rst_rsp_sel", 32'(rsp_sel), 32'd3);
        check("rst_level", 32'(level), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);

        // Single-command latency for each table vector
        for (int i = 0; i < 5; i++) begin
            rsp_ready = 1'b1;
            drive(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sel);
            check("vec_cmd_ready", 32'(cmd_ready), 32'd1);
            @(negedge clk);
            cmd_valid = 1'b0;
            check("vec_n_level", 32'(level), 32'd1);
            check("vec_n_alu_sel", 32'(alu_sel), 32'd3);
            @(negedge clk);
            check("vec_n1_alu_sel", 32'(alu_sel), 32'(vecs[i].sel));
            check("vec_n1_alu_a", 32'(alu_a), 32'(vecs[i].a));
            check("vec_n1_alu_b", 32'(alu_b), 32'(vecs[i].b));
            check("vec_n1_rsp_valid", 32'(rsp_valid), 32'd0);
            check("vec_n1_level", 32'(level), 32'd0);
            @(negedge clk);
            check("vec_n2_rsp_valid", 32'(rsp_valid), 32'd1);
            check("vec_n2_rsp_result", 32'(rsp_result), 32'(vecs[i].exp_result));
            check("vec_n2_rsp_carry", 32'(rsp_carry), 32'(vecs[i].exp_carry));
            check("vec_n2_rsp_sel", 32'(rsp_sel), 32'(vecs[i].sel));
            check("vec_n2_alu_sel", 32'(alu_sel), 32'd3);
            @(negedge clk);
            check("vec_n3_rsp_valid", 32'(rsp_valid), 32'd0);
            check("vec_n3_busy", 32'(busy), 32'd0);
        end

        // Stall in HOLD for 10 cycles, then exactly one handshake
        rsp_ready = 1'b0;
        drive(8'h3C, 8'hC3, 1'b1, ALU_MUL);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_rsp_result", 32'(rsp_result), 32'h3CC1);
            check("stall_rsp_carry", 32'(rsp_carry), 32'd1);
            check("stall_rsp_sel", 32'(rsp_sel), 32'(ALU_MUL));
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        hs = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid && rsp_ready) hs++;
            @(negedge clk);
        end
        check("stall_handshakes", 32'(hs), 32'd1);
        wait_idle();

        // Back-to-back pushes with rsp_ready low until the FIFO fills
        rsp_ready = 1'b0;
        k = 0;
        for (int cyc = 0; cyc < 10 && k < 5; cyc++) begin
            drive(8'(k), 8'(k + 1), 1'b0, ALU_SUB);
            acc = cmd_ready;
            @(negedge clk);
            if (acc) k++;
        end
        drive(8'h77, 8'h77, 1'b0, ALU_SUB);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b_accepted", 32'(k), 32'd5);
        check("b2b_level_full", 32'(level), 32'd4);
        check("b2b_cmd_ready", 32'(cmd_ready), 32'd0);
        check("b2b_busy", 32'(busy), 32'd1);
        rsp_ready = 1'b1;
        rx = 0;
        last = 0;
        for (int cyc = 0; cyc < 30 && rx < 5; cyc++) begin
            if (rsp_valid) begin
                check("b2b_rsp_result", 32'(rsp_result), 32'(stub(8'(rx), 8'(rx + 1), ALU_SUB)));
                check("b2b_rsp_sel", 32'(rsp_sel), 32'(ALU_SUB));
                if (rx > 0) check("b2b_spacing", 32'(cyc - last), 32'd2);
                last = cyc;
                rx++;
            end
            @(negedge clk);
        end
        check("b2b_rsp_count", 32'(rx), 32'd5);
        wait_idle();

        // Same-edge push/pop at level 2, then pointer wrap over 12 commands
        rsp_ready = 1'b0;
        tx = 0;
        rx = 0;
        for (int i = 0; i < 3; i++) begin
            drive(q_a[tx], q_b[tx], q_cin[tx], q_sel[tx]);
            acc = cmd_ready;
            @(negedge clk);
            if (acc) tx++;
        end
        check("wrap_level_pre", 32'(level), 32'd2);
        check("wrap_hold_valid", 32'(rsp_valid), 32'd1);
        drive(q_a[tx], q_b[tx], q_cin[tx], q_sel[tx]);
        rsp_ready = 1'b1;
        check("wrap_rsp0_result", 32'(rsp_result), 32'(stub(q_a[0], q_b[0], q_sel[0])));
        rx = 1;
        acc = cmd_ready;
        @(negedge clk);
        if (acc) tx++;
        check("same_edge_level", 32'(level), 32'd2);
        for (int cyc = 0; cyc < 100 && rx < 12; cyc++) begin
            if (tx < 12) drive(q_a[tx], q_b[tx], q_cin[tx], q_sel[tx]);
            else cmd_valid = 1'b0;
            if (rsp_valid) begin
                check("wrap_rsp_result", 32'(rsp_result), 32'(stub(q_a[rx], q_b[rx], q_sel[rx])));
                check("wrap_rsp_carry", 32'(rsp_carry), 32'(q_cin[rx]));
                check("wrap_rsp_sel", 32'(rsp_sel), 32'(q_sel[rx]));
                rx++;
            end
            acc = cmd_valid && cmd_ready;
            @(negedge clk);
            if (acc) tx++;
        end
        cmd_valid = 1'b0;
        check("wrap_rsp_count", 32'(rx), 32'd12);
        wait_idle();

        // Reset pulse while in EXEC with 3 queued commands
        rsp_ready = 1'b0;
        tx = 0;
        for (int i = 0; i < 4; i++) begin
            drive(8'(8'h50 + i), 8'(8'h60 + i), 1'b0, (i == 1) ? ALU_SUB : ALU_ADD);
            acc = cmd_ready;
            @(negedge clk);
            if (acc) tx++;
        end
        rsp_ready = 1'b1;
        drive(8'h54, 8'h64, 1'b0, ALU_ADD);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rstp_pushed", 32'(tx), 32'd4);
        check("rstp_level", 32'(level), 32'd3);
        check("rstp_exec_sel", 32'(alu_sel), 32'(ALU_SUB));
        rst_n = 1'b0;
        #1;
        check("rstp_alu_a", 32'(alu_a), 32'd0);
        check("rstp_alu_b", 32'(alu_b), 32'd0);
        check("rstp_alu_sel", 32'(alu_sel), 32'd3);
        check("rstp_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstp_rsp_result", 32'(rsp_result), 32'd0);
        check("rstp_rsp_sel", 32'(rsp_sel), 32'd3);
        check("rstp_level", 32'(level), 32'd0);
        check("rstp_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rstp_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rstp_release_ready", 32'(cmd_ready), 32'd1);
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) vcount++;
        end
        check("rstp_no_rsp", 32'(vcount), 32'd0);
        check("rstp_level_after", 32'(level), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
